vram_arbiter: RTL
=================

# vram_arbiter

Shares the single-port video RAM between the CRTC display fetch and the Z80 CPU. Each CRTC character period (one `CLKEN` pulse) is split into `SLOTS` CLOCK-cycle phases. Phase 0 is reserved for the display fetch at the CRTC's `MA`/`RA` address. The remaining phases serve at most one outstanding CPU access, with a wait handshake back to the CPU. It sits between the CRTC, the CPU bus decode and the video RAM.

## Interface
Parameters:
- `ADDR_W`, 14, video RAM address width; must be ≥ 4.
- `SLOTS`, 4, CLOCK cycles per character period; legal range 2..16.

Ports:
- `CLOCK`  in  1  system clock; all logic on rising edge.
- `nRESET`  in  1  asynchronous, active-low reset.
- `CLKEN`  in  1  character-clock enable, same strobe that advances the CRTC.
- `MA`  in  14  CRTC memory address.
- `RA`  in  5  CRTC raster line.
- `DE`  in  1  CRTC display enable.
- `GFX`  in  1  0 = text addressing, 1 = graphics addressing.
- `vid_data`  out  8  fetched display byte.
- `vid_valid`  out  1  one-cycle pulse when `vid_data` updates.
- `cpu_req`  in  1  CPU access request, level; held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; sampled at grant.
- `cpu_addr`  in  ADDR_W  CPU address; sampled at grant.
- `cpu_din`  in  8  CPU write data; sampled at grant.
- `cpu_dout`  out  8  read data; valid while `cpu_ack` is high, held afterwards.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_wait`  out  1  `cpu_req & ~cpu_ack`, combinational.
- `mem_addr`  out  ADDR_W  RAM address, registered.
- `mem_we`  out  1  RAM write strobe, registered.
- `mem_wdata`  out  8  RAM write data, registered.
- `mem_rdata`  in  8  RAM read data; one-cycle latency after address.

## Operation
- Phase counter `ph`, 0..SLOTS-1:
  - A cycle with `CLKEN`=1 loads `ph`=0 for the next cycle, at any phase. This resyncs irregular `CLKEN`.
  - Otherwise `ph` increments, saturating at SLOTS-1.
- Display address:
  - `GFX`=0: `MA[ADDR_W-1:0]`.
  - `GFX`=1: `{MA[ADDR_W-4:0], RA[2:0]}`.
- Display slot, `ph`=0:
  - Drive the display address onto `mem_addr` with `mem_we`=0.
  - Set `disp_pend`.
- Display capture: the cycle after the display slot latches `mem_rdata` into `vid_data` and pulses `vid_valid`.
- CPU FSM states `IDLE`, `ISSUE`, `ACK`:
  - `IDLE`→`ISSUE` when `cpu_req`=1 and the next cycle is a CPU slot. At this transition, capture `cpu_we`, `cpu_addr` and `cpu_din`.
  - In `ISSUE` the captured access drives the `mem_*` outputs.
  - `ISSUE`→`ACK` unconditionally.
  - In `ACK`, pulse `cpu_ack`. If the access was a read, latch `mem_rdata` into `cpu_dout`.
  - `ACK`→`IDLE` unconditionally. `cpu_req` must drop in the cycle after `ACK`; if it is still high, a new access is granted.
- CPU slot: any cycle whose `ph`≠0 and that does not follow a `CLKEN` cycle.
- Priority: the display slot always wins. A grant is never issued into the cycle following `CLKEN`.
- An `ISSUE` in phase SLOTS-1 overlapping a `CLKEN` resync is legal. Its `ACK` coincides with the display slot, because the RAM is pipelined.
- `mem_we` is asserted only in `ISSUE` with a captured write.
- An idle slot drives `mem_addr` held, `mem_we`=0.

## Timing
- Reset values: `vid_data`=0, `vid_valid`=0, `cpu_dout`=0, `cpu_ack`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `ph`=SLOTS-1, FSM=`IDLE`, `disp_pend`=0.
- Display latency: `CLKEN` at cycle t → `mem_addr` display at t+1 → `vid_data`/`vid_valid` at t+2.
- CPU latency: `cpu_req` rising at cycle t in a CPU slot → `ISSUE` at t+1 → `cpu_ack` at t+2.
- Worst-case `cpu_wait`: 3 cycles, when the request coincides with `CLKEN`.
- Reset mid-access: the access is abandoned, with no `cpu_ack` and no `mem_we`. `cpu_wait` follows `cpu_req` until re-granted.
- With `SLOTS`=2 and `CLKEN` every 2 cycles: one CPU access per character maximum.

## Configuration
- `VRAM_ARB_BLANK_STEAL_EN` defined:
  - When `DE`=0 in the `CLKEN` cycle, phase 0 becomes a CPU slot.
  - `vid_data` is forced to 0 and `vid_valid` still pulses at t+2.
- Undefined: phase 0 is always a display fetch, regardless of `DE`.

## Structure
- Package `vram_arb_pkg`:
  - FSM state enum `{IDLE, ISSUE, ACK}`.
  - Localparam `PH_DISP`=0.
  - Phase-width function `$clog2(SLOTS)`.
- Sub-module `vram_addr_mux`: combinational display-address composition (`MA`, `RA`, `GFX` → address). The arbiter instantiates it once.

## Test plan
- Reset then `CLKEN` every 4 cycles, `MA`=0x0123, `GFX`=0, RAM[0x0123]=0x5A → `mem_addr`=0x0123 at t+1; `vid_data`=0x5A with `vid_valid` at t+2.
- `GFX`=1, `MA`=0x0045, `RA`=5 → display address 0x022D.
- CPU write 0xA7 to 0x1000 requested at phase 1 → `mem_we`=1, `mem_addr`=0x1000 at phase 2; `cpu_ack` at phase 3; `cpu_wait` high for 2 cycles.
- CPU read asserted in the same cycle as `CLKEN` → display fetch first; `ISSUE` at phase 1; `cpu_ack` with `cpu_dout`=RAM data 3 cycles after the request.
- `DE`=0 with `VRAM_ARB_BLANK_STEAL_EN` and a request at `CLKEN` → CPU `ISSUE` in phase 0 and `vid_data`=0. Without the macro → display fetch in phase 0.
- `nRESET` asserted during `ISSUE` of a write → no `cpu_ack`; after release the request is re-granted and completes once.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared types and constants for the video RAM arbiter.
//   cpu_state_t : CPU access FSM states (IDLE, ISSUE, ACK)
//   PH_DISP     : phase index reserved for the display fetch
//   ph_width()  : width of the phase counter for a given SLOTS value
// -----------------------------------------------------------------------------
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } cpu_state_t;

    localparam int PH_DISP = 0;

    function automatic int ph_width(input int slots);
        return $clog2(slots);
    endfunction

endpackage

// File: rtl/vram_addr_mux.sv
// -----------------------------------------------------------------------------
// vram_addr_mux
// Composes the display fetch address from the CRTC outputs.
//   MA        in  14      CRTC memory address
//   RA        in  5       CRTC raster line (only RA[2:0] is used)
//   GFX       in  1       0 = text (MA only), 1 = graphics ({MA, RA[2:0]})
//   disp_addr out ADDR_W  video RAM address of the display byte
// ADDR_W must lie in 4..14.
// -----------------------------------------------------------------------------
module vram_addr_mux
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [13:0]       MA,
    input  logic [4:0]        RA,
    input  logic              GFX,
    output logic [ADDR_W-1:0] disp_addr
);

    // Graphics mode interleaves eight raster lines per character cell, so
    // only the low three raster bits take part in the address.
    logic unused_ra;
    assign unused_ra = ^RA[4:3];

    assign disp_addr = GFX ? {MA[ADDR_W-4:0], RA[2:0]} : MA[ADDR_W-1:0];

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares the single-port video RAM between the CRTC display fetch and the CPU.
// Each character period (one CLKEN pulse) is split into SLOTS phases; phase 0
// fetches the display byte, the other phases serve one CPU access at a time.
//
// Ports
//   CLOCK, nRESET          clock, asynchronous active-low reset
//   CLKEN                  character clock enable (resyncs the phase counter)
//   MA, RA, DE, GFX        CRTC address, raster, display enable, mode
//   vid_data, vid_valid    fetched display byte and its one-cycle strobe
//   cpu_req/we/addr/din    CPU request (level, held until cpu_ack)
//   cpu_dout, cpu_ack      read data and one-cycle completion pulse
//   cpu_wait               cpu_req & ~cpu_ack
//   mem_addr/we/wdata      registered RAM controls
//   mem_rdata              RAM read data, one cycle after mem_addr
//
// Build option
//   VRAM_ARB_BLANK_STEAL_EN : when DE=0 in the CLKEN cycle, phase 0 becomes a
//                             CPU slot and the captured display byte reads 0.
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int SLOTS  = 4
) (
    input  logic              CLOCK,
    input  logic              nRESET,
    input  logic              CLKEN,
    input  logic [13:0]       MA,
    input  logic [4:0]        RA,
    input  logic              DE,
    input  logic              GFX,
    output logic [7:0]        vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int             PW      = ph_width(SLOTS);
    localparam logic [PW-1:0] PH_LAST = PW'(SLOTS - 1);
    localparam logic [PW-1:0] PH_ZERO = PW'(PH_DISP);

    logic [PW-1:0]     ph;
    logic [ADDR_W-1:0] disp_addr;
    logic              steal;      // phase 0 of the coming period goes to the CPU
    logic              blank_cap;  // the display byte being captured is forced to 0
    logic              disp_load;  // next cycle is a display fetch
    logic              disp_pend;  // this cycle captures the display byte
    logic              grant;
    logic              cap_we;
    logic              ack_rd;
    logic [7:0]        vid_q;
    logic [7:0]        dout_q;
    cpu_state_t        state, state_nx;

    vram_addr_mux #(.ADDR_W(ADDR_W)) u_addr_mux (
        .MA        (MA),
        .RA        (RA),
        .GFX       (GFX),
        .disp_addr (disp_addr)
    );

`ifdef VRAM_ARB_BLANK_STEAL_EN
    logic blank_slot;

    assign steal = CLKEN & ~DE;

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            blank_slot <= 1'b0;
            blank_cap  <= 1'b0;
        end else begin
            blank_slot <= steal;
            blank_cap  <= blank_slot;
        end
    end
`else
    logic unused_de;

    assign steal     = 1'b0;
    assign blank_cap = 1'b0;
    assign unused_de = DE;
`endif

    // Phase counter: CLKEN forces phase 0 next cycle wherever we are, so an
    // irregular character clock simply restarts the period.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET)
            ph <= PH_LAST;
        else if (CLKEN)
            ph <= PH_ZERO;
        else if (ph != PH_LAST)
            ph <= ph + PW'(1);
    end

    assign disp_load = CLKEN & ~steal;

    // A grant always targets the next cycle; that cycle is a CPU slot unless
    // CLKEN is about to hand it to the display fetch.
    assign grant = (state == IDLE) & cpu_req & (~CLKEN | steal);

    // CPU FSM: state register
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // CPU FSM: next state
    // NOTE: every variable written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ISSUE;
            ISSUE:   state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // CPU FSM: outputs
    always_comb begin
        cpu_ack = 1'b0;
        ack_rd  = 1'b0;
        if (state == ACK) begin
            cpu_ack = 1'b1;
            ack_rd  = ~cap_we;
        end
    end

    assign cpu_wait = cpu_req & ~cpu_ack;

    // RAM controls are loaded one cycle ahead of the slot they serve. The
    // display load and a CPU grant never coincide, so ISSUE holds the values
    // captured at grant and an idle slot just holds the address.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            cap_we    <= 1'b0;
        end else if (disp_load) begin
            mem_addr  <= disp_addr;
            mem_we    <= 1'b0;
        end else if (grant) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_din;
            cap_we    <= cpu_we;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    // Read data arrives the cycle after the address, i.e. in the capture
    // cycle and in ACK. It is passed straight through in that cycle and held
    // in a register afterwards.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            disp_pend <= 1'b0;
            vid_q     <= 8'h00;
            dout_q    <= 8'h00;
        end else begin
            disp_pend <= (ph == PH_ZERO);
            if (disp_pend)
                vid_q <= vid_data;
            if (ack_rd)
                dout_q <= mem_rdata;
        end
    end

    assign vid_valid = disp_pend;
    assign vid_data  = !disp_pend ? vid_q :
                       blank_cap  ? 8'h00 : mem_rdata;
    assign cpu_dout  = ack_rd ? mem_rdata : dout_q;

endmodule
